// File: rtl/mem_access_unit_pkg.sv
// Shared types for the CPU memory stage: memory op codes, FSM states and byte-lane geometry.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        OP_LDR  = 2'd0,
        OP_STR  = 2'd1,
        OP_LDRB = 2'd2,
        OP_STRB = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LD_WAIT,
        ST_RMW_READ,
        ST_WR_BUSY
    } mem_state_t;

    localparam int BYTE_W = 8;

    function automatic logic op_is_load(mem_op_t op);
        return (op == OP_LDR) || (op == OP_LDRB);
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper: the byte addressed by a byte op always lives in the word's MSB lane.
module mem_byte_lane
    import mem_access_unit_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] word,
    input  logic [BYTE_W-1:0]    store_byte,
    output logic [BIT_WIDTH-1:0] load_byte,
    output logic [BIT_WIDTH-1:0] merged
);

    assign load_byte = {{(BIT_WIDTH-BYTE_W){1'b0}}, word[BIT_WIDTH-1 -: BYTE_W]};
    assign merged    = {store_byte, word[BIT_WIDTH-BYTE_W-1:0]};

endmodule

// File: rtl/mem_access_unit.sv
// CPU memory stage: one LDR/STR/LDRB/STRB in flight, drives data_memory, returns one response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int BIT_WIDTH = 32,
    parameter int REG_W     = 4
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    input  logic [REG_W-1:0]     req_rd,
    output logic                 resp_valid,
    output logic                 resp_is_load,
    output logic                 resp_err,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic [REG_W-1:0]     resp_rd,
    output logic [BIT_WIDTH-1:0] mem_read_addr,
    input  logic [BIT_WIDTH-1:0] mem_read_value,
    output logic                 mem_write_enable,
    output logic [BIT_WIDTH-1:0] mem_write_addr,
    output logic [BIT_WIDTH-1:0] mem_write_value
);

    localparam logic [BIT_WIDTH-1:0] ADDR_LIMIT = BIT_WIDTH'(4 * (DATA_SIZE - 1));

    mem_state_t           state;
    mem_op_t              op_in;
    mem_op_t              cap_op;
    logic [BIT_WIDTH-1:0] cap_addr;
    logic [BYTE_W-1:0]    cap_wbyte;
    logic                 in_range;
    logic [BIT_WIDTH-1:0] load_byte;
    logic [BIT_WIDTH-1:0] merged;

    assign op_in     = mem_op_t'(req_op);
    assign in_range  = req_addr < ADDR_LIMIT;
    assign req_ready = (state == ST_IDLE);

    mem_byte_lane #(.BIT_WIDTH(BIT_WIDTH)) u_byte_lane (
        .word       (mem_read_value),
        .store_byte (cap_wbyte),
        .load_byte  (load_byte),
        .merged     (merged)
    );

    // The accept-cycle access is driven straight from req_*; reset gates every port so a
    // write in progress is withdrawn the moment nreset falls.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mem_read_addr    = '0;
        mem_write_enable = 1'b0;
        mem_write_addr   = '0;
        mem_write_value  = '0;
        if (nreset) begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && in_range) begin
                        if (op_in == OP_STR) begin
                            mem_write_enable = 1'b1;
                            mem_write_addr   = req_addr;
                            mem_write_value  = req_wdata;
                        end else begin
                            mem_read_addr = req_addr;
                        end
                    end
                end
                ST_RMW_READ: begin
                    mem_write_enable = 1'b1;
                    mem_write_addr   = cap_addr;
                    mem_write_value  = merged;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= ST_IDLE;
            cap_op       <= OP_LDR;
            cap_addr     <= '0;
            cap_wbyte    <= '0;
            resp_valid   <= 1'b0;
            resp_is_load <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            resp_rd      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            resp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_op    <= op_in;
                        cap_addr  <= req_addr;
                        cap_wbyte <= req_wdata[BYTE_W-1:0];
                        resp_rd   <= req_rd;
                        if (!in_range) begin
                            resp_valid   <= 1'b1;
                            resp_err     <= 1'b1;
                            resp_is_load <= op_is_load(op_in);
                            resp_rdata   <= '0;
                        end else begin
                            unique case (op_in)
                                OP_STR:  state <= ST_WR_BUSY;
                                OP_STRB: state <= ST_RMW_READ;
                                default: state <= ST_LD_WAIT;
                            endcase
                        end
                    end
                end
                ST_LD_WAIT: begin
                    resp_valid   <= 1'b1;
                    resp_err     <= 1'b0;
                    resp_is_load <= 1'b1;
                    resp_rdata   <= (cap_op == OP_LDRB) ? load_byte : mem_read_value;
                    state        <= ST_IDLE;
                end
                ST_RMW_READ: state <= ST_WR_BUSY;
                ST_WR_BUSY: begin
                    resp_valid   <= 1'b1;
                    resp_err     <= 1'b0;
                    resp_is_load <= 1'b0;
                    resp_rdata   <= '0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random ops against a word-array model,
// and a reset-during-read-modify-write sequence.
module tb_mem_access_unit;

    localparam logic [1:0] LDR  = 2'd0;
    localparam logic [1:0] STR  = 2'd1;
    localparam logic [1:0] LDRB = 2'd2;
    localparam logic [1:0] STRB = 2'd3;
    localparam int LIMIT = 252;

    logic        clk = 1'b0;
    logic        nreset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_rd;
    logic        resp_valid;
    logic        resp_is_load;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_rd;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_value;
    logic        mem_write_enable;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_value;

    mem_access_unit dut (
        .clk              (clk),
        .nreset           (nreset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .resp_valid       (resp_valid),
        .resp_is_load     (resp_is_load),
        .resp_err         (resp_err),
        .resp_rdata       (resp_rdata),
        .resp_rd          (resp_rd),
        .mem_read_addr    (mem_read_addr),
        .mem_read_value   (mem_read_value),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_value  (mem_write_value)
    );

    always #5 clk = ~clk;

    // Stand-in for data_memory: registered read, write commits on the edge after we.
    logic [31:0] tb_mem [64];
    always @(posedge clk) begin
        mem_read_value <= tb_mem[mem_read_addr[7:2]];
        if (mem_write_enable) tb_mem[mem_write_addr[7:2]] <= mem_write_value;
    end

    // Reference model: what each word of memory should hold, and which words were written.
    logic [31:0] ref_mem [64];
    logic        written [64];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the request into the current cycle (N) and checks the
    // whole transaction, leaving the bench at the negedge of the response cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] rd, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input logic [31:0] exp_wv);
        int  lat;
        int  idx;
        logic is_load;
        is_load = (op == LDR) || (op == LDRB);
        idx = int'(addr[7:2]);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        #1;
        check("ready_in_idle", 32'(req_ready), 32'd1);
        check("n_read_addr", mem_read_addr, (!exp_err && op != STR) ? addr : 32'd0);
        check("n_write_en", 32'(mem_write_enable), 32'(!exp_err && op == STR));
        if (!exp_err && op == STR) begin
            check("n_write_addr", mem_write_addr, addr);
            check("n_write_value", mem_write_value, exp_wv);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !exp_err) begin
                check("n1_write_en", 32'(mem_write_enable), 32'(op == STRB));
                if (op == STRB) begin
                    check("n1_write_addr", mem_write_addr, addr);
                    check("n1_write_value", mem_write_value, exp_wv);
                end else begin
                    check("n1_read_addr", mem_read_addr, 32'd0);
                end
            end
            if (resp_valid || lat >= 6) break;
            check("busy_not_ready", 32'(req_ready), 32'd0);
            // Junk request while busy must be ignored.
            req_valid = 1'b1;
            req_op    = STR;
            req_addr  = 32'h30;
            req_wdata = 32'hBADBAD00;
        end
        req_valid = 1'b0;
        check($sformatf("latency_op%0d_a%h", op, addr), 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("resp_is_load", 32'(resp_is_load), 32'(is_load));
        check($sformatf("resp_rdata_op%0d_a%h", op, addr), resp_rdata, exp_rdata);
        check("resp_rd", 32'(resp_rd), 32'(rd));
        if (!exp_err) begin
            if (op == STR) begin
                ref_mem[idx] = wdata;
                written[idx] = 1'b1;
            end else if (op == STRB) begin
                ref_mem[idx] = {wdata[7:0], ref_mem[idx][23:0]};
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wv;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wv;
        logic        err;
        int          idx;
        int          lat;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 32'd0;
            written[i] = 1'b0;
        end

        vecs[0]  = '{STR,  32'h08,       32'hDEADBEEF, 4'd1,  32'h0,        1'b0, 2, 32'hDEADBEEF};
        vecs[1]  = '{STR,  32'h10,       32'h01020304, 4'd2,  32'h0,        1'b0, 2, 32'h01020304};
        vecs[2]  = '{STR,  32'hF8,       32'hCAFEF00D, 4'd3,  32'h0,        1'b0, 2, 32'hCAFEF00D};
        vecs[3]  = '{LDR,  32'h08,       32'h0,        4'd4,  32'hDEADBEEF, 1'b0, 2, 32'h0};
        vecs[4]  = '{STR,  32'h05,       32'h11223344, 4'd5,  32'h0,        1'b0, 2, 32'h11223344};
        vecs[5]  = '{LDR,  32'h05,       32'h0,        4'd6,  32'h11223344, 1'b0, 2, 32'h0};
        vecs[6]  = '{STRB, 32'h10,       32'h000000AB, 4'd7,  32'h0,        1'b0, 3, 32'hAB020304};
        vecs[7]  = '{LDRB, 32'h10,       32'h0,        4'd8,  32'h000000AB, 1'b0, 2, 32'h0};
        vecs[8]  = '{LDR,  32'hFC,       32'h0,        4'd9,  32'h0,        1'b1, 1, 32'h0};
        vecs[9]  = '{STRB, 32'hFC,       32'h0000005A, 4'd10, 32'h0,        1'b1, 1, 32'h0};
        vecs[10] = '{STR,  32'hFFFFFFF0, 32'h12345678, 4'd11, 32'h0,        1'b1, 1, 32'h0};
        vecs[11] = '{LDR,  32'hFB,       32'h0,        4'd12, 32'hCAFEF00D, 1'b0, 2, 32'h0};
        vecs[12] = '{LDRB, 32'h09,       32'h0,        4'd13, 32'h000000DE, 1'b0, 2, 32'h0};
        vecs[13] = '{LDRB, 32'hFC,       32'h0,        4'd14, 32'h0,        1'b1, 1, 32'h0};

        // Reset with a live in-range request: ports must stay quiet.
        nreset    = 1'b0;
        req_valid = 1'b1;
        req_op    = STR;
        req_addr  = 32'h08;
        req_wdata = 32'h55555555;
        req_rd    = 4'd0;
        #3;
        check("rst_write_en", 32'(mem_write_enable), 32'd0);
        check("rst_write_addr", mem_write_addr, 32'd0);
        check("rst_read_addr", mem_read_addr, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            do_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                  vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_wv);

        // Random traffic against the word-array model.
        for (int i = 0; i < 60; i++) begin
            op    = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255))
                                               : 32'($urandom_range(0, 47));
            wdata = $urandom;
            rd    = 4'($urandom_range(0, 15));
            idx   = int'(addr[7:2]);
            err   = (addr >= 32'(LIMIT));
            if (!err && op != STR && !written[idx]) op = STR;
            exp_rdata = 32'd0;
            if (!err && op == LDR)  exp_rdata = ref_mem[idx];
            if (!err && op == LDRB) exp_rdata = {24'd0, ref_mem[idx][31:24]};
            exp_wv = (op == STR) ? wdata : {wdata[7:0], ref_mem[idx][23:0]};
            lat = err ? 1 : ((op == STRB) ? 3 : 2);
            do_op(op, addr, wdata, rd, exp_rdata, err, lat, exp_wv);
        end

        // Reset while the byte store is in its write cycle: write withdrawn, no response.
        do_op(STR, 32'h20, 32'h99887766, 4'd1, 32'h0, 1'b0, 2, 32'h99887766);
        req_valid = 1'b1;
        req_op    = STRB;
        req_addr  = 32'h20;
        req_wdata = 32'h00000055;
        req_rd    = 4'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1;
        check("rmw_write_en", 32'(mem_write_enable), 32'd1);
        nreset = 1'b0;
        #1;
        check("midrst_write_en", 32'(mem_write_enable), 32'd0);
        check("midrst_write_addr", mem_write_addr, 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", 32'(resp_valid), 32'd0);
            check("post_rst_ready", 32'(req_ready), 32'd1);
        end
        do_op(LDR, 32'h20, 32'h0, 4'd3, 32'h99887766, 1'b0, 2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
